fetch_prefetch_unit: RTL and testbench

Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register.
- Generates the fetch PC and issues word requests to instruction memory over a valid/ready handshake.
- Buffers returned {pc, instruction} pairs in a small prefetch FIFO, so a multi-cycle memory does not starve decode.
- Presents the FIFO head to IF/ID, honours the hazard-unit stall, and flushes on a taken branch or jump redirect from ID.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 79 +++++++
 rtl/fetch_prefetch_unit.sv | 173 +++++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned XLEN        = 64;
  localparam int unsigned ILEN        = 32;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} pairs; head is read straight from flop storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    clear,
  input  entry_t                  wdata,
  output entry_t                  rdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic [$clog2(DEPTH):0]  count_nxt_c,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            pop_ok;
  logic            push_ok;

  // Next-state: clear wins; pop on empty is ignored; push on full only alongside a pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata       = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign count_nxt_c = count_d;
  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch PC generation, one-outstanding imem requests and prefetch buffering toward IF/ID.
// Optional build macro FETCH_PERF_CNT_EN adds saturating fetched/dropped/starve counters.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [63:0]            redirect_pc,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [63:0]            imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [31:0]            imem_rsp_data,
  output logic                   out_valid,
  output logic [31:0]            out_instr,
  output logic [63:0]            out_pc,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_dropped,
  output logic [31:0]            perf_starve
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   req_pc_q, req_pc_d;
  logic          req_valid_q, req_valid_d;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic          rsp_drop;
  logic          fifo_empty;
  logic          unused_fifo_full;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;
  logic [1:0]    unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[1:0];
  assign req_fire            = req_valid_q && imem_req_ready;
  assign push_entry          = {req_pc_q, imem_rsp_data};

  // Next-state and FIFO control; redirect overrides push, pop and the normal transition.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    push       = 1'b0;
    rsp_drop   = 1'b0;
    pop        = !fifo_empty && !stall && !redirect_valid;
    case (state_q)
      REQ: begin
        if (req_fire) begin
          state_d    = WAIT;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 64'(INSTR_BYTES);
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          state_d = REQ;
          push    = 1'b1;
        end
      end
      DROP: begin
        if (imem_rsp_valid) begin
          state_d  = REQ;
          rsp_drop = 1'b1;
        end
      end
      default: state_d = REQ;
    endcase
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[63:2], 2'b00};
      push       = 1'b0;
      rsp_drop   = imem_rsp_valid && (state_q != REQ);
      // A request is still in flight if one was just accepted or the awaited response has not come.
      if ((state_q == REQ) ? req_fire : !imem_rsp_valid) begin
        state_d = DROP;
      end else begin
        state_d = REQ;
      end
    end
  end

  // Request valid is registered: asserted for the coming cycle when in REQ with a free slot.
  always_comb begin
    req_valid_d = (state_d == REQ) && (count_nxt < CW'(DEPTH));
  end

  // FSM and fetch registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= REQ;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .clear       (redirect_valid),
    .wdata       (push_entry),
    .rdata       (head_entry),
    .count       (count),
    .count_nxt_c (count_nxt),
    .full        (unused_fifo_full),
    .empty       (fifo_empty)
  );

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = fetch_pc_q;
  assign out_valid      = !fifo_empty;
  assign out_pc         = head_entry.pc;
  assign out_instr      = head_entry.instr;
  assign fifo_count     = count;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_dropped_q, perf_dropped_d;
  logic [31:0] perf_starve_q, perf_starve_d;

  // Saturating event counters.
  always_comb begin
    perf_fetched_d = sat_inc32(perf_fetched_q, push);
    perf_dropped_d = sat_inc32(perf_dropped_q, rsp_drop);
    perf_starve_d  = sat_inc32(perf_starve_q, fifo_empty && !stall && !redirect_valid);
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
      perf_starve_q  <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_dropped_q <= perf_dropped_d;
      perf_starve_q  <= perf_starve_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
  assign perf_starve  = perf_starve_q;
`else
  logic unused_perf;
  assign unused_perf = rsp_drop;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: queue-level reference model, per-cycle compare, directed scenarios.
module tb_fetch_prefetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_dropped, perf_starve;
`endif

  always #5 clk = ~clk;

  fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fifo_count     (fifo_count)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped),
    .perf_starve    (perf_starve)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Reference model state
  ent_t        m_q[$];
  logic [63:0] m_pc;
  logic [63:0] m_opc;
  bit          m_started, m_out, m_stale, m_acc, m_rsp;
  int          m_fetched, m_dropped, m_starve;
  // Memory model state
  bit          mem_busy;
  int          mem_wait;
  logic [63:0] mem_addr;
  int          lat = 1;

  logic [63:0] popped[$];
  bit          chk_en = 1'b0;
  int          n;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  function automatic bit m_req_valid();
    return m_started && !m_out && (m_q.size() < int'(DEPTH));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=bound_expired expected=event t=%0t", nm, $time);
  endtask

  // Model: FIFO as a queue, at most one outstanding request, stale flag after redirect.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_pc = RESET_PC; m_opc = '0;
      m_started = 0; m_out = 0; m_stale = 0;
      m_fetched = 0; m_dropped = 0; m_starve = 0;
      mem_busy = 0; mem_wait = 0; mem_addr = '0;
    end else begin
      m_acc = m_req_valid() && imem_req_ready;
      m_rsp = imem_rsp_valid;
      if (m_q.size() == 0 && !stall && !redirect_valid) m_starve++;
      if (m_rsp) mem_busy = 0;
      else if (mem_busy && mem_wait > 0) mem_wait--;
      if (m_acc) begin mem_busy = 1; mem_wait = lat - 1; mem_addr = m_pc; end
      if (redirect_valid) begin
        m_q.delete();
        if (m_rsp && m_out) m_dropped++;
        m_out   = m_acc || (m_out && !m_rsp);
        m_stale = m_out;
        m_pc    = {redirect_pc[63:2], 2'b00};
      end else begin
        if (m_q.size() > 0 && !stall) void'(m_q.pop_front());
        if (m_rsp && m_out) begin
          if (m_stale) m_dropped++;
          else begin m_q.push_back('{m_opc, mem_word(m_opc)}); m_fetched++; end
          m_out = 0; m_stale = 0;
        end
        if (m_acc) begin m_out = 1; m_stale = 0; m_opc = m_pc; m_pc = m_pc + 64'd4; end
      end
      m_started = 1;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_valid", 64'(imem_req_valid), 64'(m_req_valid()));
      if (m_req_valid()) chk("req_addr", imem_req_addr, m_pc);
      chk("fifo_count", 64'(fifo_count), 64'(m_q.size()));
      chk("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        chk("out_pc", out_pc, m_q[0].pc);
        chk("out_instr", 64'(out_instr), 64'(m_q[0].instr));
      end
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
      chk("perf_dropped", 64'(perf_dropped), 64'(m_dropped));
      chk("perf_starve", 64'(perf_starve), 64'(m_starve));
`endif
      if (rst && out_valid && !stall && !redirect_valid) popped.push_back(out_pc);
    end
  end

  // One cycle; the memory model drives its response for the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    imem_rsp_valid = rst && mem_busy && (mem_wait == 0);
    imem_rsp_data  = mem_word(mem_addr);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    popped.delete();
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Zero-wait memory, no stall
    lat = 1; stall = 0; imem_req_ready = 1;
    do_reset();
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("first_entry_ticks", 64'(n), 64'd3);
    chk("first_pc", out_pc, 64'h0);
    chk("first_instr", 64'(out_instr), 64'h1357_9BDF);
    repeat (8) tick();
    chk("zw_pop_count", 64'(popped.size()), 64'd4);
    if (popped.size() >= 4) begin
      chk("zw_pop0", popped[0], 64'h0);
      chk("zw_pop1", popped[1], 64'h4);
      chk("zw_pop2", popped[2], 64'h8);
      chk("zw_pop3", popped[3], 64'hC);
    end

    // Stall fills the FIFO and blocks requests
    stall = 1;
    do_reset();
    repeat (12) tick();
    chk("stall_count", 64'(fifo_count), 64'd4);
    chk("stall_req_valid", 64'(imem_req_valid), 64'd0);
    chk("stall_out_pc", out_pc, 64'h0);
    stall = 0;
    repeat (10) tick();
    if (popped.size() >= 4) begin
      chk("stall_pop0", popped[0], 64'h0);
      chk("stall_pop1", popped[1], 64'h4);
      chk("stall_pop2", popped[2], 64'h8);
      chk("stall_pop3", popped[3], 64'hC);
    end else timeout_fail("stall_pops");

    // Redirect while waiting on 0x10
    lat = 3; stall = 0;
    do_reset();
    n = 0;
    while (!(m_out && !m_stale && m_opc == 64'h10 && !imem_rsp_valid) && n < 200) begin tick(); n++; end
    if (n >= 200) timeout_fail("wait_0x10");
    redirect_valid = 1; redirect_pc = 64'h100;
    tick();
    redirect_valid = 0;
    chk("redir_addr", imem_req_addr, 64'h100);
    chk("redir_count", 64'(fifo_count), 64'd0);
    chk("redir_out_valid", 64'(out_valid), 64'd0);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    if (n >= 50) timeout_fail("land_0x100");
    chk("redir_head", out_pc, 64'h100);
`ifdef FETCH_PERF_CNT_EN
    chk("redir_perf_dropped", 64'(perf_dropped), 64'd1);
`endif
    repeat (6) tick();

    // Misaligned redirect coinciding with a response
    lat = 1; stall = 1;
    do_reset();
    n = 0;
    while (!(m_q.size() >= 2 && imem_rsp_valid) && n < 100) begin tick(); n++; end
    if (n >= 100) timeout_fail("rsp_with_entries");
    redirect_valid = 1; redirect_pc = 64'h203;
    tick();
    redirect_valid = 0;
    chk("r203_count", 64'(fifo_count), 64'd0);
    chk("r203_out_valid", 64'(out_valid), 64'd0);
    chk("r203_req_valid", 64'(imem_req_valid), 64'd1);
    chk("r203_addr", imem_req_addr, 64'h200);
    stall = 0;
    repeat (8) tick();

    // Back-pressure on the request at 0x20
    lat = 1; stall = 0; imem_req_ready = 1;
    do_reset();
    n = 0;
    while (!(m_started && !m_out && m_pc == 64'h20) && n < 100) begin tick(); n++; end
    if (n >= 100) timeout_fail("reach_0x20");
    imem_req_ready = 0;
    repeat (5) begin
      tick();
      chk("hold_valid", 64'(imem_req_valid), 64'd1);
      chk("hold_addr", imem_req_addr, 64'h20);
    end
    imem_req_ready = 1;
    repeat (8) tick();
    if (popped.size() >= 10) begin
      chk("bp_pop8", popped[8], 64'h20);
      chk("bp_pop9", popped[9], 64'h24);
    end else timeout_fail("bp_pops");

    // Asynchronous reset mid-transaction
    lat = 3; stall = 0;
    do_reset();
    n = 0;
    while (!(m_out && m_opc == 64'h8) && n < 100) begin tick(); n++; end
    if (n >= 100) timeout_fail("wait_0x8");
    rst = 0;
    #1;
    chk("arst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("arst_req_addr", imem_req_addr, 64'h0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_pc", out_pc, 64'h0);
    chk("arst_out_instr", 64'(out_instr), 64'h0);
    chk("arst_count", 64'(fifo_count), 64'd0);
    tick();
    tick();
    rst = 1;
    chk("rel_req_valid_pre", 64'(imem_req_valid), 64'd0);
    tick();
    chk("rel_req_valid", 64'(imem_req_valid), 64'd1);
    chk("rel_req_addr", imem_req_addr, RESET_PC);
    repeat (12) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
